// File: rtl/cpu_pkg.sv
// Shared encodings for the fetch/PC stage and its neighbours:
// next-PC selects, fetch FSM states and the NOP word.
package cpu_pkg;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_J   = 2'b10;
    localparam logic [1:0] PC_JR  = 2'b11;

    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_FETCH = 2'b01,
        S_EXEC  = 2'b10
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc_unit_next_pc.sv
// next_pc_calc: combinational next-PC selection and PC+4 link value.
// Ports: pc, instr, PCsrc, rs_data in; next_pc, pc_plus4, misalign out.
module next_pc_calc
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [31:0]       instr,
    input  logic [1:0]        PCsrc,
    input  logic [31:0]       rs_data,
    output logic [ADDR_W-1:0] next_pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              misalign
);

    logic [ADDR_W-1:0] w_br_off;
    logic [ADDR_W-1:0] w_j_tgt;
    logic [ADDR_W-1:0] w_jr_tgt;
    logic              w_unused;

    assign pc_plus4 = pc + ADDR_W'(4);

    // Word offset, sign-extended and scaled to bytes.
    assign w_br_off = {{(ADDR_W-18){instr[15]}}, instr[15:0], 2'b00};

    // Jump keeps the region bits of the sequential address.
    assign w_j_tgt  = {pc_plus4[ADDR_W-1:28], instr[25:0], 2'b00};

    assign w_jr_tgt = ADDR_W'({rs_data[31:2], 2'b00});

    // Opcode bits are decoded elsewhere.
    assign w_unused = ^instr[31:26];

    assign misalign = (PCsrc == PC_JR) && (rs_data[1:0] != 2'b00);

    always_comb begin
        next_pc = pc_plus4;
        unique case (PCsrc)
            PC_SEQ: next_pc = pc_plus4;
            PC_BR:  next_pc = pc_plus4 + w_br_off;
            PC_J:   next_pc = w_j_tgt;
            PC_JR:  next_pc = w_jr_tgt;
        endcase
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: PC register and single-outstanding instruction fetch FSM.
// Ports: clk/reset; imem_req/addr/ready/rdata fetch handshake;
// instr/instr_valid/pc/pc_plus4 to decode; PCsrc/rs_data/commit from
// control; align_err (FETCH_ALIGN_CHECK_EN enables misaligned-jr check).
module fetch_pc_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    input  logic [1:0]        PCsrc,
    input  logic [31:0]       rs_data,
    input  logic              commit,
    output logic              align_err
);

`ifdef FETCH_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    fetch_state_t      r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [31:0]       r_instr;
    logic              r_instr_valid;
    logic              r_imem_req;

    logic [ADDR_W-1:0] w_next_pc;
    logic [ADDR_W-1:0] w_pc_plus4;
    logic [ADDR_W-1:0] w_pc_load;
    logic              w_misalign;

    next_pc_calc #(
        .ADDR_W   (ADDR_W)
    ) u_next_pc (
        .pc       (r_pc),
        .instr    (r_instr),
        .PCsrc    (PCsrc),
        .rs_data  (rs_data),
        .next_pc  (w_next_pc),
        .pc_plus4 (w_pc_plus4),
        .misalign (w_misalign)
    );

    // A rejected jr falls through to the sequential address.
    assign w_pc_load = (ALIGN_CHK && w_misalign) ? w_pc_plus4 : w_next_pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_instr       <= NOP;
            r_instr_valid <= 1'b0;
            r_imem_req    <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_state    <= S_FETCH;
                    r_imem_req <= 1'b1;
                end
                S_FETCH: begin
                    if (imem_ready) begin
                        r_instr       <= imem_rdata;
                        r_instr_valid <= 1'b1;
                        r_imem_req    <= 1'b0;
                        r_state       <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (commit) begin
                        r_pc          <= w_pc_load;
                        r_instr_valid <= 1'b0;
                        r_imem_req    <= 1'b1;
                        r_state       <= S_FETCH;
                    end
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_instr_valid <= 1'b0;
                    r_imem_req    <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    logic r_align_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_align_err <= 1'b0;
        end else if (r_state == S_EXEC && commit && w_misalign) begin
            r_align_err <= 1'b1;
        end
    end

    assign align_err = r_align_err;
`else
    assign align_err = 1'b0;
`endif

    assign imem_req    = r_imem_req;
    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign pc_plus4    = w_pc_plus4;
    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Randomised bench for fetch_pc_unit with an arithmetic reference model.
// Optional FETCH_ALIGN_CHECK_EN changes the expected jr behaviour.
module tb_fetch_pc_unit;

`ifdef FETCH_ALIGN_CHECK_EN
    localparam bit ALN = 1'b1;
`else
    localparam bit ALN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [1:0]  PCsrc = 2'b00;
    logic [31:0] rs_data = '0;
    logic        commit = 1'b0;
    logic        align_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_pc;
    logic        m_aerr;

    fetch_pc_unit dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .PCsrc       (PCsrc),
        .rs_data     (rs_data),
        .commit      (commit),
        .align_err   (align_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_next(input logic [31:0] cur,
            input logic [31:0] w, input logic [1:0] src,
            input logic [31:0] rs);
        logic [31:0] p4;
        int          off;
        p4 = cur + 32'd4;
        case (src)
            2'd0: return p4;
            2'd1: begin
                off = int'($signed(w[15:0])) * 4;
                return p4 + 32'(off);
            end
            2'd2: return (p4 & 32'hF000_0000) + ({6'd0, w[25:0]} * 32'd4);
            default: begin
                if (ALN && (rs % 4 != 0)) return p4;
                return rs - (rs % 4);
            end
        endcase
    endfunction

    // Entered at a negedge with the DUT in S_FETCH; leaves it there again.
    task automatic do_instr(input logic [31:0] w, input int wait_n,
                            input int cdelay, input logic [1:0] src,
                            input logic [31:0] rs);
        for (int i = 0; i < wait_n; i++) begin
            imem_ready = 1'b0;
            imem_rdata = $urandom;
            commit     = $urandom_range(0, 1);
            check("wait_req", imem_req, 1);
            check("wait_addr", imem_addr, m_pc);
            check("wait_valid", instr_valid, 0);
            @(negedge clk);
        end
        commit = 1'b0;
        check("fetch_req", imem_req, 1);
        check("fetch_addr", imem_addr, m_pc);
        imem_ready = 1'b1;
        imem_rdata = w;
        @(negedge clk);
        imem_ready = 1'b0;
        imem_rdata = $urandom;
        check("exec_valid", instr_valid, 1);
        check("exec_instr", instr, w);
        check("exec_req", imem_req, 0);
        check("exec_pc", pc, m_pc);
        check("exec_p4", pc_plus4, m_pc + 32'd4);
        for (int i = 0; i < cdelay; i++) begin
            imem_ready = $urandom_range(0, 1);
            PCsrc      = 2'($urandom_range(0, 3));
            rs_data    = $urandom;
            @(negedge clk);
            check("hold_valid", instr_valid, 1);
            check("hold_instr", instr, w);
            check("hold_p4", pc_plus4, m_pc + 32'd4);
        end
        imem_ready = 1'b0;
        commit     = 1'b1;
        PCsrc      = src;
        rs_data    = rs;
        @(negedge clk);
        commit  = 1'b0;
        PCsrc   = 2'($urandom_range(0, 3));
        rs_data = $urandom;
        if (ALN && src == 2'd3 && rs[1:0] != 2'b00) m_aerr = 1'b1;
        m_pc = model_next(m_pc, w, src, rs);
        check("commit_valid", instr_valid, 0);
        check("commit_req", imem_req, 1);
        check("commit_pc", pc, m_pc);
        check("commit_instr", instr, w);
        check("align_err", align_err, m_aerr);
    endtask

    initial begin
        m_pc   = 32'h0;
        m_aerr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_pc", pc, 0);
        check("rst_req", imem_req, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_instr", instr, 0);
        check("rst_aerr", align_err, 0);
        reset = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 3; k++)
            do_instr(32'h2008_0005, 0, 0, 2'd0, 32'h0);
        check("seq_pc", pc, 32'hC);

        do_instr(32'h0, 0, 1, 2'd3, 32'h40);
        do_instr(32'h1000_FFFE, 0, 0, 2'd1, 32'h0);
        check("br_back", imem_addr, 32'h3C);
        do_instr(32'h1000_FFFF, 1, 0, 2'd1, 32'h0);
        check("self_loop", imem_addr, 32'h3C);

        do_instr(32'h0, 0, 0, 2'd3, 32'h8000_0010);
        do_instr(32'h0C00_0100, 0, 2, 2'd2, 32'h0);
        check("jal_tgt", pc, 32'h8000_0400);

        do_instr(32'h0, 0, 0, 2'd3, 32'hFFFF_FFFC);
        do_instr(32'h0, 0, 0, 2'd0, 32'h0);
        check("wrap", pc, 32'h0);

        do_instr(32'h0, 0, 0, 2'd3, 32'h0000_1236);
        check("jr_mis", pc, ALN ? 32'h4 : 32'h1234);
        check("jr_aerr", align_err, ALN ? 32'h1 : 32'h0);

        do_instr(32'h0, 5, 0, 2'd0, 32'h0);

        for (int k = 0; k < 40; k++)
            do_instr($urandom, $urandom_range(0, 3), $urandom_range(0, 2),
                     2'($urandom_range(0, 3)), $urandom);

        do_instr(32'h0, 0, 0, 2'd3, 32'h100);
        imem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("wait100_req", imem_req, 1);
        check("wait100_addr", imem_addr, 32'h100);
        reset = 1'b1;
        @(negedge clk);
        reset      = 1'b0;
        imem_ready = 1'b1;
        m_pc   = 32'h0;
        m_aerr = 1'b0;
        check("mid_rst_pc", pc, 0);
        check("mid_rst_req", imem_req, 0);
        check("mid_rst_valid", instr_valid, 0);
        check("mid_rst_aerr", align_err, 0);
        @(negedge clk);
        imem_ready = 1'b0;
        check("refetch_req", imem_req, 1);
        check("refetch_addr", imem_addr, 32'h0);
        check("refetch_valid", instr_valid, 0);
        do_instr(32'h2008_0005, 2, 0, 2'd0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Instruction-fetch and program-counter stage that sits directly upstream of the control unit.
- Holds the PC and fetches one instruction per step from instruction memory through a ready handshake.
- Presents the latched instruction, so decode and control can derive op/funct from it.
- Computes the next PC from the control unit's PCsrc selection, the branch offset and jump field in the latched instruction, and the jr register value. It also provides PC+4 as the JAL link value.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word aligned.
- ADDR_W, 32, PC and instruction-address width.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous reset, active-high.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  ADDR_W  fetch address; always equals pc.
- imem_ready  in  1  instruction memory has valid data this cycle.
- imem_rdata  in  32  instruction word, sampled when imem_req && imem_ready.
- instr  out  32  latched instruction; [31:26] feeds control op, [5:0] feeds funct.
- instr_valid  out  1  instr is valid and being executed.
- pc  out  ADDR_W  address of the current instruction.
- pc_plus4  out  ADDR_W  pc+4, used as the JAL link value.
- PCsrc  in  2  next-PC select from the control unit.
- rs_data  in  32  register rs value, used as the jr target.
- commit  in  1  datapath has finished the current instruction.
- align_err  out  1  sticky misaligned-jr flag; tied 0 unless the optional feature is enabled.

Behaviour:
- **Reset** (synchronous, active-high, overrides everything including mid-handshake):
  - pc=RESET_PC, state=S_IDLE, instr=32'h0, instr_valid=0, imem_req=0, align_err=0.
- **FSM** (S_IDLE, S_FETCH, S_EXEC):
  - S_IDLE: entered only from reset. Goes to S_FETCH unconditionally next cycle.
  - S_FETCH: imem_req=1 and imem_addr=pc. Stays until imem_ready=1. On the ready edge: instr<=imem_rdata, instr_valid<=1, go to S_EXEC. Minimum fetch latency is one cycle (ready may arrive in the first S_FETCH cycle). The wait length is unbounded.
  - S_EXEC: imem_req=0 and instr_valid=1. When commit=1: pc<=next_pc, instr_valid<=0, go to S_FETCH. instr holds its value until the next fetch completes.
- **Input qualification**:
  - commit is ignored outside S_EXEC.
  - imem_ready is ignored outside S_FETCH.
  - PCsrc and rs_data are sampled only on the commit edge.
- **next_pc** (with p4 = pc+4, mod 2^ADDR_W):
  - 2'b00 (sequential): p4.
  - 2'b01 (branch taken): p4 + (signext(instr[15:0])<<2), wrapping mod 2^ADDR_W.
  - 2'b10 (j/jal): {p4[31:28], instr[25:0], 2'b00}.
  - 2'b11 (jr): rs_data with bits [1:0] forced to 00.
- **Timing of derived outputs**:
  - pc_plus4 is combinational from pc.
  - pc_plus4 is stable for the whole of S_EXEC, so JAL writeback on commit sees the correct link.
- **Boundaries**:
  - pc=32'hFFFF_FFFC with sequential select wraps to 0.
  - Branch offset 16'hFFFF jumps to pc (p4-4), giving a self-loop.
  - A reset asserted while a fetch is waiting abandons it; imem_req is 0 from the next cycle, and any late imem_ready is ignored.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined:
  - A jr commit with rs_data[1:0]!=0 sets align_err=1 (sticky until reset).
  - pc loads p4 instead of the jr target.
- Undefined:
  - The low two bits are silently masked.
  - align_err is constant 0.

Decomposition:
- Shared package cpu_pkg holds:
  - PCsrc encodings PC_SEQ=2'b00, PC_BR=2'b01, PC_J=2'b10, PC_JR=2'b11.
  - FSM state encodings.
  - NOP constant 32'h0.
- One combinational sub-module, next_pc_calc, with inputs pc, instr, PCsrc and rs_data, and outputs next_pc, pc_plus4 and misalign.

Test Plan:
- Reset, then imem_ready held 1, imem_rdata=32'h2008_0005, commit on the cycle after instr_valid rises:
  - imem_addr sequence is 0, 4, 8.
  - instr_valid is high for one cycle per instruction.
  - pc_plus4=4 during the first S_EXEC.
- pc=32'h40, instr=32'h1000_FFFE, PCsrc=01, commit -> next imem_addr is 32'h3C.
- pc=32'h8000_0010, instr=32'h0C00_0100 (jal), PCsrc=10 -> pc_plus4=32'h8000_0014 during S_EXEC; next pc=32'h8000_0400.
- PCsrc=11 with rs_data=32'h0000_1236:
  - Without the macro: pc=32'h1234.
  - With FETCH_ALIGN_CHECK_EN: pc=old pc+4 and align_err=1, staying 1 until reset.
- imem_ready withheld for 5 cycles, then pulsed:
  - imem_req stays high the whole time and imem_addr is stable.
  - instr_valid rises exactly one cycle after the ready pulse.
- reset pulsed during a wait in S_FETCH with pc=32'h100:
  - Next cycle: pc=RESET_PC, imem_req=0, instr_valid=0.
  - One cycle later: a new fetch at RESET_PC.
